// File: rtl/pma_pkg.sv
// Shared types and the single-rule range check for the programmable PMA checker.
// Rule storage is sized for the widest supported physical address.
package pma_pkg;

    localparam int unsigned MaxAddrWidth = 64;

    typedef struct packed {
        logic n;
        logic c;
        logic x;
    } pma_attr_t;

    typedef struct packed {
        logic                    valid;
        logic                    lock;
        pma_attr_t               attr;
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] len;
    } pma_rule_t;

    // One extra bit on the limit so base+len never wraps; len=0 can never match.
    function automatic logic pma_match(input pma_rule_t rule,
                                       input logic [MaxAddrWidth-1:0] addr);
        logic [MaxAddrWidth:0] lim;
        lim = {1'b0, rule.base} + {1'b0, rule.len};
        return rule.valid && (addr >= rule.base) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/pma_range_match.sv
// Combinational matcher: does one address fall inside one programmed rule.
module pma_range_match
    import pma_pkg::*;
(
    input  pma_rule_t                rule_i,
    input  logic [MaxAddrWidth-1:0]  addr_i,
    output logic                     match_o
);

    assign match_o = pma_match(rule_i, addr_i);

endmodule

// File: rtl/pma_checker_prog.sv
// Runtime-programmable PMA checker: NrRules lockable regions, NrPorts independent
// lookup channels, each with a one-entry registered valid/ready response.
module pma_checker_prog
    import pma_pkg::*;
#(
    parameter int unsigned NrRules   = 16,
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_we_i,
    input  logic [IdxW-1:0]              cfg_idx_i,
    input  logic [AddrWidth-1:0]         cfg_base_i,
    input  logic [AddrWidth-1:0]         cfg_len_i,
    input  logic [2:0]                   cfg_attr_i,
    input  logic                         cfg_valid_i,
    input  logic                         cfg_lock_i,
    output logic                         cfg_err_o,
    input  logic [NrPorts-1:0]           req_valid_i,
    output logic [NrPorts-1:0]           req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0] req_addr_i,
    output logic [NrPorts-1:0]           rsp_valid_o,
    input  logic [NrPorts-1:0]           rsp_ready_i,
    output logic [NrPorts-1:0]           rsp_hit_o,
    output logic [NrPorts*IdxW-1:0]      rsp_idx_o,
    output logic [NrPorts-1:0]           rsp_exec_o,
    output logic [NrPorts-1:0]           rsp_cache_o,
    output logic [NrPorts-1:0]           rsp_nonidem_o
);

    pma_rule_t rules_q [NrRules];
    pma_rule_t rules_d [NrRules];
    logic      cfg_err_q, cfg_err_d;

    logic [MaxAddrWidth-1:0] addr_ext [NrPorts];
    logic                    match    [NrPorts][NrRules];
    logic                    any_x;

    logic [NrPorts-1:0] hit_c, exec_c, cache_c, nonidem_c, xmatch_c;
    logic [IdxW-1:0]    idx_c [NrPorts];

    logic [NrPorts-1:0] rsp_valid_q, rsp_valid_d;
    logic [NrPorts-1:0] rsp_hit_q, rsp_hit_d;
    logic [NrPorts-1:0] rsp_exec_q, rsp_exec_d;
    logic [NrPorts-1:0] rsp_cache_q, rsp_cache_d;
    logic [NrPorts-1:0] rsp_nonidem_q, rsp_nonidem_d;
    logic [IdxW-1:0]    rsp_idx_q [NrPorts];
    logic [IdxW-1:0]    rsp_idx_d [NrPorts];
    logic [NrPorts-1:0] accept;

    // Out-of-range indices match no k, so they fall through to the error path.
    always_comb begin
        rules_d   = rules_q;
        cfg_err_d = 1'b0;
        if (cfg_we_i) begin
            cfg_err_d = 1'b1;
            for (int k = 0; k < int'(NrRules); k++) begin
                if (cfg_idx_i == IdxW'(k) && !rules_q[k].lock) begin
                    rules_d[k] = '{valid: cfg_valid_i,
                                   lock:  cfg_lock_i,
                                   attr:  pma_attr_t'(cfg_attr_i),
                                   base:  MaxAddrWidth'(cfg_base_i),
                                   len:   MaxAddrWidth'(cfg_len_i)};
                    cfg_err_d  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        any_x = 1'b0;
        for (int k = 0; k < int'(NrRules); k++) begin
            any_x = any_x | (rules_q[k].valid & rules_q[k].attr.x);
        end
    end

    for (genvar p = 0; p < int'(NrPorts); p++) begin : g_port
        assign addr_ext[p] = MaxAddrWidth'(req_addr_i[p*AddrWidth +: AddrWidth]);
        assign rsp_idx_o[p*IdxW +: IdxW] = rsp_idx_q[p];
        for (genvar k = 0; k < int'(NrRules); k++) begin : g_rule
            pma_range_match u_match (
                .rule_i  (rules_q[k]),
                .addr_i  (addr_ext[p]),
                .match_o (match[p][k])
            );
        end
    end

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            hit_c[p]     = 1'b0;
            idx_c[p]     = '0;
            cache_c[p]   = 1'b0;
            nonidem_c[p] = 1'b0;
            xmatch_c[p]  = 1'b0;
            for (int k = int'(NrRules) - 1; k >= 0; k--) begin
                if (match[p][k]) begin
                    hit_c[p]     = 1'b1;
                    idx_c[p]     = IdxW'(k);
                    cache_c[p]   = cache_c[p] | rules_q[k].attr.c;
                    nonidem_c[p] = nonidem_c[p] | rules_q[k].attr.n;
                    xmatch_c[p]  = xmatch_c[p] | rules_q[k].attr.x;
                end
            end
            exec_c[p] = !any_x | xmatch_c[p];
        end
    end

    assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_exec_d    = rsp_exec_q;
        rsp_cache_d   = rsp_cache_q;
        rsp_nonidem_d = rsp_nonidem_q;
        rsp_idx_d     = rsp_idx_q;
        for (int p = 0; p < int'(NrPorts); p++) begin
            if (accept[p]) begin
                rsp_valid_d[p]   = 1'b1;
                rsp_hit_d[p]     = hit_c[p];
                rsp_exec_d[p]    = exec_c[p];
                rsp_cache_d[p]   = cache_c[p];
                rsp_nonidem_d[p] = nonidem_c[p];
                rsp_idx_d[p]     = idx_c[p];
            end else if (rsp_ready_i[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(NrRules); k++) rules_q[k] <= '0;
            for (int p = 0; p < int'(NrPorts); p++) rsp_idx_q[p] <= '0;
            cfg_err_q     <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_hit_q     <= '0;
            rsp_exec_q    <= '0;
            rsp_cache_q   <= '0;
            rsp_nonidem_q <= '0;
        end else begin
            rules_q       <= rules_d;
            rsp_idx_q     <= rsp_idx_d;
            cfg_err_q     <= cfg_err_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_exec_q    <= rsp_exec_d;
            rsp_cache_q   <= rsp_cache_d;
            rsp_nonidem_q <= rsp_nonidem_d;
        end
    end

    assign cfg_err_o     = cfg_err_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_hit_o     = rsp_hit_q;
    assign rsp_exec_o    = rsp_exec_q;
    assign rsp_cache_o   = rsp_cache_q;
    assign rsp_nonidem_o = rsp_nonidem_q;

endmodule

// File: tb/tb_pma_checker_prog.sv
// Table-driven bench with a per-port response scoreboard for pma_checker_prog,
// plus hand sequences for stall, same-cycle write/lookup, reset and bad indices.
module tb_pma_checker_prog;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
        logic       exec;
        logic       cache;
        logic       nonidem;
    } exp_t;

    typedef struct {
        bit          is_wr;
        int          port;
        logic [3:0]  idx;
        logic [63:0] base;
        logic [63:0] len;
        logic [2:0]  attr;
        bit          valid;
        bit          lock;
        bit          err;
        logic [63:0] addr;
        exp_t        exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_idx = '0;
    logic [63:0]  cfg_base = '0;
    logic [63:0]  cfg_len = '0;
    logic [2:0]   cfg_attr = '0;
    logic         cfg_valid = 1'b0;
    logic         cfg_lock = 1'b0;
    logic         cfg_err;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [127:0] req_addr = '0;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b11;
    logic [1:0]   rsp_hit, rsp_exec, rsp_cache, rsp_nonidem;
    logic [7:0]   rsp_idx;

    logic         we12 = 1'b0;
    logic [3:0]   idx12 = '0;
    logic         err12;
    logic [1:0]   rdy12, vld12, hit12, exe12, cac12, non12;
    logic [7:0]   ridx12;

    exp_t exp_next [2];
    exp_t sb0 [$];
    exp_t sb1 [$];
    vec_t vecs [$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pma_checker_prog #(.NrRules(16), .NrPorts(2), .AddrWidth(64)) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cfg_we_i      (cfg_we),
        .cfg_idx_i     (cfg_idx),
        .cfg_base_i    (cfg_base),
        .cfg_len_i     (cfg_len),
        .cfg_attr_i    (cfg_attr),
        .cfg_valid_i   (cfg_valid),
        .cfg_lock_i    (cfg_lock),
        .cfg_err_o     (cfg_err),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_hit_o     (rsp_hit),
        .rsp_idx_o     (rsp_idx),
        .rsp_exec_o    (rsp_exec),
        .rsp_cache_o   (rsp_cache),
        .rsp_nonidem_o (rsp_nonidem)
    );

    // Non-power-of-two table so an out-of-range index is expressible.
    pma_checker_prog #(.NrRules(12), .NrPorts(2), .AddrWidth(64)) u_dut12 (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cfg_we_i      (we12),
        .cfg_idx_i     (idx12),
        .cfg_base_i    (64'h4000),
        .cfg_len_i     (64'h100),
        .cfg_attr_i    (3'b010),
        .cfg_valid_i   (1'b1),
        .cfg_lock_i    (1'b0),
        .cfg_err_o     (err12),
        .req_valid_i   (2'b00),
        .req_ready_o   (rdy12),
        .req_addr_i    (128'h0),
        .rsp_valid_o   (vld12),
        .rsp_ready_i   (2'b11),
        .rsp_hit_o     (hit12),
        .rsp_idx_o     (ridx12),
        .rsp_exec_o    (exe12),
        .rsp_cache_o   (cac12),
        .rsp_nonidem_o (non12)
    );

    function automatic exp_t ex(input logic h, input logic [3:0] i, input logic e,
                                input logic c, input logic n);
        ex = '{hit: h, idx: i, exec: e, cache: c, nonidem: n};
    endfunction

    function automatic vec_t mk_wr(input logic [3:0] i, input logic [63:0] b,
                                   input logic [63:0] l, input logic [2:0] a,
                                   input bit v, input bit lk, input bit e);
        vec_t t;
        t = '{is_wr: 1'b1, port: 0, idx: i, base: b, len: l, attr: a, valid: v,
              lock: lk, err: e, addr: '0, exp: '0};
        return t;
    endfunction

    function automatic vec_t mk_lk(input int p, input logic [63:0] ad, input exp_t e);
        vec_t t;
        t = '{is_wr: 1'b0, port: p, idx: '0, base: '0, len: '0, attr: '0, valid: 1'b0,
              lock: 1'b0, err: 1'b0, addr: ad, exp: e};
        return t;
    endfunction

    function automatic exp_t act_rsp(input int p);
        act_rsp = '{hit: rsp_hit[p], idx: rsp_idx[p*4 +: 4], exec: rsp_exec[p],
                    cache: rsp_cache[p], nonidem: rsp_nonidem[p]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: pop on consume, push on accept, both decided just before the edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            sb0.delete();
            sb1.delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected port%0d: got %0h, expected none",
                                 p, act_rsp(p));
                    end else begin
                        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
                        check($sformatf("sb_rsp port%0d", p), 64'(act_rsp(p)), 64'(e));
                    end
                end
                if (req_valid[p] && req_ready[p]) begin
                    if (p == 0) sb0.push_back(exp_next[0]);
                    else        sb1.push_back(exp_next[1]);
                end
            end
        end
    end

    task automatic wr(input logic [3:0] i, input logic [63:0] b, input logic [63:0] l,
                      input logic [2:0] a, input bit v, input bit lk, input bit e,
                      input string name);
        @(posedge clk); #2;
        cfg_we = 1'b1; cfg_idx = i; cfg_base = b; cfg_len = l;
        cfg_attr = a; cfg_valid = v; cfg_lock = lk;
        @(posedge clk); #2;
        cfg_we = 1'b0;
        check({name, "_err"}, 64'(cfg_err), 64'(e));
        @(posedge clk); #2;
        check({name, "_err_clr"}, 64'(cfg_err), 64'd0);
    endtask

    task automatic look(input int p, input logic [63:0] ad, input exp_t e, input string name);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #2;
        req_valid[p] = 1'b1;
        req_addr[p*64 +: 64] = ad;
        exp_next[p] = e;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[p]) ok = 1'b1;
        end
        @(posedge clk); #2;
        req_valid[p] = 1'b0;
        check({name, "_accept"}, 64'(ok), 64'd1);
        check({name, "_lat"}, 64'(rsp_valid[p]), 64'd1);
    endtask

    initial begin
        exp_t snap;
        exp_next[0] = '0;
        exp_next[1] = '0;

        // Rule table and expected results derived by hand from the matching rules.
        vecs.push_back(mk_lk(0, 64'h8000_0000, ex(0, 0, 1, 0, 0)));
        vecs.push_back(mk_wr(3, 64'h8000_0000, 64'h1000, 3'b011, 1, 0, 0));
        vecs.push_back(mk_lk(0, 64'h8000_0FFF, ex(1, 3, 1, 1, 0)));
        vecs.push_back(mk_lk(0, 64'h8000_1000, ex(0, 0, 0, 0, 0)));
        vecs.push_back(mk_lk(1, 64'h7FFF_FFFF, ex(0, 0, 0, 0, 0)));
        vecs.push_back(mk_lk(1, 64'h8000_0000, ex(1, 3, 1, 1, 0)));
        vecs.push_back(mk_wr(0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b100, 1, 0, 0));
        vecs.push_back(mk_lk(0, 64'hFFFF_FFFF_FFFF_FFFF, ex(1, 0, 0, 0, 1)));
        vecs.push_back(mk_lk(1, 64'hFFFF_FFFF_FFFF_EFFF, ex(0, 0, 0, 0, 0)));
        vecs.push_back(mk_wr(2, 64'h1000, 64'h100, 3'b001, 1, 1, 0));
        vecs.push_back(mk_wr(2, 64'h2000, 64'h100, 3'b010, 1, 0, 1));
        vecs.push_back(mk_lk(0, 64'h1080, ex(1, 2, 1, 0, 0)));
        vecs.push_back(mk_lk(0, 64'h2080, ex(0, 0, 0, 0, 0)));
        vecs.push_back(mk_wr(4, 64'h3000, 64'h0, 3'b010, 1, 0, 0));
        vecs.push_back(mk_lk(0, 64'h3000, ex(0, 0, 0, 0, 0)));
        vecs.push_back(mk_wr(6, 64'h8000_0800, 64'h1000, 3'b100, 1, 0, 0));
        vecs.push_back(mk_lk(1, 64'h8000_0900, ex(1, 3, 1, 1, 1)));
        vecs.push_back(mk_lk(1, 64'h8000_1400, ex(1, 6, 0, 0, 1)));
        vecs.push_back(mk_wr(7, 64'h5000, 64'h100, 3'b001, 0, 0, 0));
        vecs.push_back(mk_lk(0, 64'h5000, ex(0, 0, 0, 0, 0)));

        repeat (3) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_fields", {rsp_hit, rsp_exec, rsp_cache, rsp_nonidem, rsp_idx},
              64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd3);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr)
                wr(vecs[i].idx, vecs[i].base, vecs[i].len, vecs[i].attr, vecs[i].valid,
                   vecs[i].lock, vecs[i].err, $sformatf("tbl%0d", i));
            else
                look(vecs[i].port, vecs[i].addr, vecs[i].exp, $sformatf("tbl%0d", i));
        end

        // Port 1 backpressure: response held stable, then back-to-back reload.
        @(posedge clk); #2;
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_addr[127:64] = 64'h8000_0010;
        exp_next[1] = ex(1, 3, 1, 1, 0);
        @(posedge clk); #2;
        req_addr[127:64] = 64'h1080;
        exp_next[1] = ex(1, 2, 1, 0, 0);
        check("stall_valid0", 64'(rsp_valid[1]), 64'd1);
        snap = act_rsp(1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            check($sformatf("stall_ready%0d", c), 64'(req_ready[1]), 64'd0);
            check($sformatf("stall_valid%0d", c + 1), 64'(rsp_valid[1]), 64'd1);
            check($sformatf("stall_stable%0d", c), 64'(act_rsp(1)), 64'(snap));
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #2;
        req_valid[1] = 1'b0;
        check("b2b_valid", 64'(rsp_valid[1]), 64'd1);
        check("b2b_new", 64'(act_rsp(1)), 64'(ex(1, 2, 1, 0, 0)));

        // Write to rule 5 and a lookup inside it in the same cycle see the old table.
        @(posedge clk); #2;
        cfg_we = 1'b1; cfg_idx = 4'd5; cfg_base = 64'h9000; cfg_len = 64'h100;
        cfg_attr = 3'b010; cfg_valid = 1'b1; cfg_lock = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[63:0] = 64'h9010;
        exp_next[0] = ex(0, 0, 0, 0, 0);
        @(posedge clk); #2;
        cfg_we = 1'b0;
        req_valid[0] = 1'b0;
        check("same_cyc_err", 64'(cfg_err), 64'd0);
        look(0, 64'h9010, ex(1, 5, 0, 1, 0), "after_wr5");

        // Reset while a response is pending drops it and clears the table.
        @(posedge clk); #2;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[63:0] = 64'h8000_0000;
        exp_next[0] = ex(1, 3, 1, 1, 0);
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        check("pre_rst_valid", 64'(rsp_valid[0]), 64'd1);
        rst_ni = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_fields", {rsp_hit, rsp_exec, rsp_cache, rsp_nonidem, rsp_idx}, 64'd0);
        rst_ni = 1'b1;
        rsp_ready = 2'b11;
        look(0, 64'h8000_0000, ex(0, 0, 1, 0, 0), "post_rst_a");
        look(1, 64'h1080, ex(0, 0, 1, 0, 0), "post_rst_b");
        wr(2, 64'h2000, 64'h100, 3'b010, 1, 0, 0, "post_rst_unlock");
        look(0, 64'h2010, ex(1, 2, 1, 1, 0), "post_rst_c");

        // Out-of-range index on the 12-rule instance.
        @(posedge clk); #2;
        we12 = 1'b1; idx12 = 4'd12;
        @(posedge clk); #2;
        we12 = 1'b0;
        check("oor_err", 64'(err12), 64'd1);
        @(posedge clk); #2;
        check("oor_err_clr", 64'(err12), 64'd0);
        we12 = 1'b1; idx12 = 4'd11;
        @(posedge clk); #2;
        we12 = 1'b0;
        check("inrange_err", 64'(err12), 64'd0);

        repeat (4) @(posedge clk);
        #2;
        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
